// File: rtl/fetch_stage.sv
// Fetch stage: PC register, fetch-address legality check and the F->D
// pipeline register. The redirect priority is reset > req > eret > stall > normal.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        D_jump,
  input  logic [31:0] D_npc,
  input  logic        D_isBranch,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] EPC,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [4:0]  D_excCode,
  output logic        D_bd
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } dreg_t;

  logic [31:0] pc;
  dreg_t       d_q;
  logic        f_exc;
  logic [31:0] f_instr;

  // Illegal fetches are squashed to a nop and flagged; fetch keeps going.
  assign f_exc   = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  assign f_instr = f_exc ? 32'h0 : i_inst_rdata;

  // PC and D register update; req/eret inject a bubble tagged with the new PC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= PC_RESET;
      d_q.instr <= 32'h0;
      d_q.pc    <= PC_RESET;
      d_q.exc   <= EXC_NONE;
      d_q.bd    <= 1'b0;
    end else if (req) begin
      pc        <= EXC_ENTRY;
      d_q.instr <= 32'h0;
      d_q.pc    <= EXC_ENTRY;
      d_q.exc   <= EXC_NONE;
      d_q.bd    <= 1'b0;
    end else if (eret) begin
      // eret has no delay slot: the word fetched next is the EPC target.
      pc        <= EPC;
      d_q.instr <= 32'h0;
      d_q.pc    <= EPC;
      d_q.exc   <= EXC_NONE;
      d_q.bd    <= 1'b0;
    end else if (!stall) begin
      pc        <= D_jump ? D_npc : pc + 32'd4;
      d_q.instr <= f_instr;
      d_q.pc    <= pc;
      d_q.exc   <= f_exc ? EXC_ADEL : EXC_NONE;
      d_q.bd    <= D_isBranch;
    end
  end

  assign i_inst_addr = pc;
  assign D_instr     = d_q.instr;
  assign D_pc        = d_q.pc;
  assign D_excCode   = d_q.exc;
  assign D_bd        = d_q.bd;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a reference model pushes the expected post-edge state
// into a queue as each cycle's stimulus is driven; it is popped and compared after the edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, D_jump, D_isBranch, req, eret;
  logic [31:0] D_npc, EPC;
  logic [31:0] i_inst_addr, i_inst_rdata, D_instr, D_pc;
  logic [4:0]  D_excCode;
  logic        D_bd;

  int nchk = 0;
  int nerr = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .D_jump(D_jump), .D_npc(D_npc),
    .D_isBranch(D_isBranch), .req(req), .eret(eret), .EPC(EPC),
    .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .D_instr(D_instr), .D_pc(D_pc), .D_excCode(D_excCode), .D_bd(D_bd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign i_inst_rdata = mem(i_inst_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] dpc;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_dpc = 32'h0;
  logic [4:0]  m_exc = 5'd0;
  logic        m_bd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, push the model's expectation, compare after the edge.
  task automatic cyc(input logic rst, input logic st, input logic jmp, input logic [31:0] npc,
                     input logic br, input logic rq, input logic er, input logic [31:0] epc);
    logic  fexc;
    exp_t  e;
    reset = rst; stall = st; D_jump = jmp; D_npc = npc; D_isBranch = br;
    req = rq; eret = er; EPC = epc;
    fexc = (m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
    if (!rst) begin
      m_pc = 32'h3000; m_instr = 0; m_dpc = 32'h3000; m_exc = 0; m_bd = 0;
    end else if (rq) begin
      m_pc = 32'h4180; m_instr = 0; m_dpc = 32'h4180; m_exc = 0; m_bd = 0;
    end else if (er) begin
      m_pc = epc; m_instr = 0; m_dpc = epc; m_exc = 0; m_bd = 0;
    end else if (!st) begin
      m_instr = fexc ? 32'h0 : mem(m_pc);
      m_dpc   = m_pc;
      m_exc   = fexc ? 5'd4 : 5'd0;
      m_bd    = br;
      m_pc    = jmp ? npc : m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.dpc = m_dpc; e.exc = m_exc; e.bd = m_bd;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("pc",    i_inst_addr,        e.pc);
    chk("instr", D_instr,            e.instr);
    chk("dpc",   D_pc,               e.dpc);
    chk("exc",   {27'h0, D_excCode}, {27'h0, e.exc});
    chk("bd",    {31'h0, D_bd},      {31'h0, e.bd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] t;
    reset = 0; stall = 0; D_jump = 0; D_npc = 0; D_isBranch = 0;
    req = 0; eret = 0; EPC = 0;

    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h5000, 1, 1, 1, 32'h6000);
    chk("rst_pc",  i_inst_addr, 32'h3000);
    chk("rst_dpc", D_pc,        32'h3000);
    chk("rst_ins", D_instr,     32'h0);

    // First edge out of reset latches the word at PC_RESET; then a second run edge
    run(1);
    chk("first_ins", D_instr, mem(32'h3000));
    run(1);
    chk("run_pc",  i_inst_addr, 32'h3008);
    chk("run_dpc", D_pc,        32'h3004);
    chk("run_bd",  {31'h0, D_bd}, 32'h0);

    // Stall 3 cycles at 0x3008, with a jump request that must be ignored
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 32'h5555_0000, 1, 0, 0, 0);
    chk("stall_pc",  i_inst_addr, 32'h3008);
    chk("stall_dpc", D_pc,        32'h3004);
    run(1);
    chk("rel_pc", i_inst_addr, 32'h300C);

    // Jump with delay slot at PC=0x3010
    run(1);
    cyc(1, 0, 1, 32'h3100, 1, 0, 0, 0);
    chk("jmp_pc",  i_inst_addr, 32'h3100);
    chk("jmp_dpc", D_pc,        32'h3010);
    chk("jmp_bd",  {31'h0, D_bd}, 32'h1);

    // Misaligned target
    cyc(1, 0, 1, 32'h3002, 0, 0, 0, 0);
    run(1);
    chk("mis_exc", {27'h0, D_excCode}, 32'd4);
    chk("mis_ins", D_instr,            32'h0);
    chk("mis_dpc", D_pc,               32'h3002);

    // Out of range target: fetch continues past it
    cyc(1, 0, 1, 32'h7000, 0, 0, 0, 0);
    run(2);
    chk("oor_exc", {27'h0, D_excCode}, 32'd4);
    chk("oor_pc",  i_inst_addr,        32'h7008);

    // req beats stall and eret
    cyc(1, 1, 1, 32'h3200, 1, 1, 1, 32'h3300);
    chk("req_pc",  i_inst_addr,   32'h4180);
    chk("req_ins", D_instr,       32'h0);
    chk("req_bd",  {31'h0, D_bd}, 32'h0);
    run(2);

    // eret beats stall; next edge fetches EPC as a normal (non-delay) slot
    cyc(1, 1, 0, 0, 1, 0, 1, 32'h3020);
    chk("eret_pc",  i_inst_addr, 32'h3020);
    chk("eret_ins", D_instr,     32'h0);
    run(1);
    chk("eret_dpc", D_pc,    32'h3020);
    chk("eret_nxt", D_instr, mem(32'h3020));

    // 32-bit wrap
    cyc(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    run(1);
    chk("wrap_pc", i_inst_addr, 32'h0);

    // Reset mid-stall / mid-redirect wins the same cycle
    cyc(0, 1, 1, 32'h3400, 1, 0, 0, 0);
    chk("rst_mid_pc", i_inst_addr, 32'h3000);
    run(1);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      t = 32'h3000 + ($urandom_range(0, 32'h4100) & 32'hFFFF_FFFE);
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), t, $urandom_range(0, 1),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0),
          32'h3000 + ($urandom_range(0, 32'h1000) & 32'hFFFF_FFFC));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: FetchStage

Interface
REQ-001 The block SHALL take parameter PC_RESET, default 32'h0000_3000, the first fetch address after reset.
REQ-002 The block SHALL take parameter EXC_ENTRY, default 32'h0000_4180, the exception/interrupt handler address.
REQ-003 The block SHALL take parameters IM_LO (default 32'h0000_3000) and IM_HI (default 32'h0000_6FFC), the inclusive legal fetch range.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
REQ-006 stall  input  1  hazard-unit request to hold the PC and the D register.
REQ-007 D_jump  input  1  the instruction in D redirects the PC.
REQ-008 D_npc  input  32  redirect target, valid while D_jump=1.
REQ-009 D_isBranch  input  1  the instruction in D is a branch or jump, so the current fetch is a delay slot.
REQ-010 req  input  1  CP0 exception/interrupt request.
REQ-011 eret  input  1  the instruction in D is eret.
REQ-012 EPC  input  32  return address for eret.
REQ-013 i_inst_addr  output  32  fetch address driven to instruction memory; equals the PC register.
REQ-014 i_inst_rdata  input  32  instruction word for i_inst_addr, available in the same cycle (combinational).
REQ-015 D_instr, D_pc  output  32 each  registered instruction and its address, the decode-stage input.
REQ-016 D_excCode  output  5  registered fetch exception code; 0 = none, 4 = AdEL.
REQ-017 D_bd  output  1  registered delay-slot flag.

Function
REQ-018 F_exc SHALL be 1 when PC[1:0]!=0, PC<IM_LO or PC>IM_HI; F_instr SHALL be 0 when F_exc=1 and i_inst_rdata otherwise.
REQ-019 Each edge SHALL apply the first matching case of this priority list: reset, req, eret, stall, normal.
REQ-020 Case req: PC<=EXC_ENTRY; D_instr<=0, D_pc<=EXC_ENTRY, D_excCode<=0, D_bd<=0; stall SHALL be ignored.
REQ-021 Case eret (req=0): PC<=EPC; D_instr<=0, D_pc<=EPC, D_excCode<=0, D_bd<=0; stall SHALL be ignored; the fetch after eret SHALL NOT be executed as a delay slot.
REQ-022 Case stall (req=0, eret=0): the PC and all D outputs SHALL hold their values; D_jump SHALL be ignored.
REQ-023 Case normal: PC<=D_npc if D_jump=1, else PC<=PC+4, with 32-bit wrap-around.
REQ-024 Case normal: D_instr<=F_instr, D_pc<=PC, D_excCode<=(F_exc?4:0), D_bd<=D_isBranch.
REQ-025 Fetch latency SHALL be 1 cycle: the word at PC appears on the D outputs after the next edge.
REQ-026 An illegal PC SHALL NOT halt fetch; it is reported through D_excCode, and the PC advances per REQ-023 until req is raised.
REQ-027 If req and eret are both 1, req SHALL win.

Reset
REQ-028 While reset=0 at an edge: PC<=PC_RESET, D_instr<=0, D_pc<=PC_RESET, D_excCode<=0, D_bd<=0; all other inputs SHALL be ignored.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending state and SHALL take effect in that same cycle.
REQ-030 The first edge with reset=1 SHALL latch the word at PC_RESET into D.

Verification
REQ-031 Reset then run: 2 normal edges -> i_inst_addr=0x3008, D_pc=0x3004, D_bd=0.
REQ-032 Jump: PC=0x3010, D_jump=1, D_npc=0x3100, D_isBranch=1 -> next i_inst_addr=0x3100, D_pc=0x3010, D_bd=1.
REQ-033 Stall: stall=1 for 3 cycles at PC=0x3008 -> PC and D outputs unchanged; after release -> PC=0x300C.
REQ-034 Misaligned PC: D_jump with D_npc=0x3002 -> next D_excCode=4, D_instr=0, D_pc=0x3002; out-of-range PC 0x7000 -> D_excCode=4.
REQ-035 req with stall=1 and eret=1 -> PC=0x4180, D_instr=0, D_bd=0.
REQ-036 eret with EPC=0x3020 -> PC=0x3020, D_instr=0; next edge -> D_pc=0x3020.
